// File: rtl/filtros_s2_pkg.sv
// ---------------------------------------------------------------------------
// filtros_s2_pkg
// Shared definitions for the stage-2 convolution weight bank.
//   - Geometry constants of the bank (filters, channels, kernel size).
//   - weight_t   : one signed coefficient, 16 fractional bits.
//   - filt_arr_t : one filter, indexed [canal][columna][fila]. It has the
//                  same layout as the fixed filter ROM, so the datapath can
//                  take weights from either source.
//   - state_t    : loader FSM states.
// ---------------------------------------------------------------------------
package filtros_s2_pkg;

  localparam int WIDTH          = 17;
  localparam int NUM_FILT       = 4;
  localparam int NCH            = 3;
  localparam int KSIZE          = 3;
  localparam int WORDS_PER_FILT = NCH * KSIZE * KSIZE;
  localparam int TOTAL_WORDS    = NUM_FILT * WORDS_PER_FILT;

  typedef logic signed [16:0] weight_t;

  typedef weight_t [2:0][2:0][2:0] filt_arr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/filtros_s2_addr_cnt.sv
// ---------------------------------------------------------------------------
// filtros_s2_addr_cnt
// Word-position counter for the weight stream. Instead of keeping a flat
// word index and decoding it with divide/modulo, it keeps four nested
// counters that roll over in stream order: row fastest, then column,
// channel and finally filter.
//
// Ports:
//   clk       : clock, rising edge.
//   rst_n     : asynchronous active-low reset, all counters to 0.
//   clr_i     : synchronous clear back to word 0 (wins over inc_i).
//   inc_i     : advance to the next word position.
//   row_o     : row within the kernel column (0..2).
//   col_o     : kernel column (0..2).
//   ch_o      : input channel (0..2).
//   filt_o    : filter number (0..3).
//   is_last_o : high while the position is the final word of the bank.
// ---------------------------------------------------------------------------
module filtros_s2_addr_cnt
  import filtros_s2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [1:0] row_o,
  output logic [1:0] col_o,
  output logic [1:0] ch_o,
  output logic [1:0] filt_o,
  output logic       is_last_o
);

  localparam logic [1:0] RowLast  = 2'(KSIZE - 1);
  localparam logic [1:0] ColLast  = 2'(KSIZE - 1);
  localparam logic [1:0] ChLast   = 2'(NCH - 1);
  localparam logic [1:0] FiltLast = 2'(NUM_FILT - 1);

  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [1:0] ch_q,  ch_d;
  logic [1:0] filt_q, filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      ch_q   <= '0;
      filt_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      ch_q   <= ch_d;
      filt_q <= filt_d;
    end
  end

  // Ripple carry between the nested counters; after the final word of the
  // bank the whole counter wraps to position 0.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    ch_d   = ch_q;
    filt_d = filt_q;
    if (clr_i) begin
      row_d  = '0;
      col_d  = '0;
      ch_d   = '0;
      filt_d = '0;
    end else if (inc_i) begin
      if (row_q == RowLast) begin
        row_d = '0;
        if (col_q == ColLast) begin
          col_d = '0;
          if (ch_q == ChLast) begin
            ch_d = '0;
            if (filt_q == FiltLast) begin
              filt_d = '0;
            end else begin
              filt_d = filt_q + 2'd1;
            end
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end else begin
        row_d = row_q + 2'd1;
      end
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign ch_o      = ch_q;
  assign filt_o    = filt_q;
  assign is_last_o = (row_q == RowLast) && (col_q == ColLast) &&
                     (ch_q == ChLast) && (filt_q == FiltLast);

endmodule

// File: rtl/filtros_s2_weight_loader.sv
// ---------------------------------------------------------------------------
// filtros_s2_weight_loader
// Writable weight bank for the stage-2 convolution. A serial stream of 108
// coefficients is written into a shadow buffer; only after a complete,
// well-formed load is the shadow copied into the active bank, all words on
// one edge, so the datapath never sees a half-written bank.
//
// Ports:
//   clk        : clock, rising edge.
//   rst_n      : asynchronous active-low reset.
//   load_start : one-cycle pulse, starts a load (only honoured in IDLE).
//   s_data     : coefficient word, stored bit-exact.
//   s_valid    : s_data / s_last valid.
//   s_ready    : high in LOAD; a word is taken when s_valid && s_ready.
//   s_last     : marks the final (108th) word of the bank.
//   Filtro1..4 : active bank, indexed [canal][columna][fila].
//   bank_valid : a bank has been committed since reset.
//   busy       : load in progress (LOAD or COMMIT).
//   done       : one-cycle pulse after a commit.
//   err        : sticky framing error, cleared when a new load starts.
// ---------------------------------------------------------------------------
module filtros_s2_weight_loader
  import filtros_s2_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   load_start,
  input  logic signed [WIDTH-1:0]                s_data,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic                                   s_last,
  output logic signed [2:0][2:0][2:0][WIDTH-1:0] Filtro1,
  output logic signed [2:0][2:0][2:0][WIDTH-1:0] Filtro2,
  output logic signed [2:0][2:0][2:0][WIDTH-1:0] Filtro3,
  output logic signed [2:0][2:0][2:0][WIDTH-1:0] Filtro4,
  output logic                                   bank_valid,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   done_q, done_d;
  logic   bank_valid_q, bank_valid_d;

  // Both banks are plain flops: the commit copies every word in parallel.
  filt_arr_t [NUM_FILT-1:0] shadow_q;
  filt_arr_t [NUM_FILT-1:0] active_q;

  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_last;
  logic       shadow_we;
  logic       commit;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [1:0] ch_idx;
  logic [1:0] filt_idx;

  filtros_s2_addr_cnt u_addr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .row_o     (row_idx),
    .col_o     (col_idx),
    .ch_o      (ch_idx),
    .filt_o    (filt_idx),
    .is_last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      bank_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      done_q       <= done_d;
      bank_valid_q <= bank_valid_d;
    end
  end

  // Framing check happens on the accepting edge: s_last must coincide with
  // the final word position. Either mismatch abandons the load without
  // touching the active bank; the shadow is simply overwritten next time.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    done_d       = 1'b0;
    bank_valid_d = bank_valid_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    shadow_we    = 1'b0;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          shadow_we = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            if (s_last) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end else if (s_last) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        commit       = 1'b1;
        bank_valid_d = 1'b1;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shadow buffer: one word written per accepted beat at the counter position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (shadow_we) begin
      shadow_q[filt_idx][ch_idx][col_idx][row_idx] <= s_data;
    end
  end

  // Active bank: replaced as a whole on the single COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
    end else if (commit) begin
      active_q <= shadow_q;
    end
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign bank_valid = bank_valid_q;
  assign Filtro1    = active_q[0];
  assign Filtro2    = active_q[1];
  assign Filtro3    = active_q[2];
  assign Filtro4    = active_q[3];

endmodule
